vmem_lane_sequencer: RTL and testbench

//   Sequences vector loads/stores onto one single-ported lane-wide vector data memory.

---
 rtl/vmem_lane_sequencer_if.sv | 32 +++
 rtl/vmem_lane_sequencer.sv | 107 ++++++++++
 tb/tb_vmem_lane_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vmem_lane_sequencer_if.sv
// Bundle for the vector unit's request/response and the shared vector data memory port.
// slave = the sequencer, master = the vector unit plus the memory it drives.
interface vmem_lane_sequencer_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4,
    parameter int ADDR_W = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_W-1:0]       req_base;
    logic [ADDR_W-1:0]       req_stride;
    logic [LANES*LANE_W-1:0] req_wdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [LANE_W-1:0]       mem_wdata;
    logic [LANE_W-1:0]       mem_rdata;
    logic                    resp_valid;
    logic [LANES*LANE_W-1:0] resp_rdata;
    logic                    busy;

    modport slave (
        input  req_valid, req_write, req_base, req_stride, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, busy
    );

    modport master (
        output req_valid, req_write, req_base, req_stride, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/vmem_lane_sequencer.sv
// Serialises one strided vector load/store into LANES single-element accesses
// on a shared single-ported memory, returning the packed result with a one-cycle pulse.
module vmem_lane_sequencer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vmem_lane_sequencer_if.slave  bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LW-1:0]           r_lane;
    logic                    r_write;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       r_stride;
    logic [LANES*LANE_W-1:0] r_wdata;
    logic [LANES*LANE_W-1:0] r_rdata;
    logic [LANES*LANE_W-1:0] w_rdata_next;
    logic                    r_cap_pend;
    logic [LW-1:0]           r_cap_lane;
    logic [LANE_W-1:0]       r_acc [LANES-1];

    logic w_accept;
    logic w_issue;
    logic w_last;
    logic w_en;

    assign w_accept = (r_state == S_IDLE) & bus.req_valid;
    assign w_issue  = (r_state == S_ISSUE);
    assign w_last   = (r_lane == LAST_LANE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_state_next = S_ISSUE;
            S_ISSUE: if (w_last) w_state_next = r_write ? S_RESP : S_WAIT;
            S_WAIT:  w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // r_addr walks base, base+stride, ... so no multiplier is needed; wrap is natural.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_stride   <= '0;
            r_wdata    <= '0;
            r_cap_pend <= 1'b0;
            r_cap_lane <= '0;
            r_rdata    <= '0;
        end else begin
            r_cap_pend <= w_issue & ~r_write;
            r_cap_lane <= r_lane;
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_addr   <= bus.req_base;
                r_stride <= bus.req_stride;
                r_wdata  <= bus.req_wdata;
                r_lane   <= '0;
            end else if (w_issue) begin
                r_addr <= r_addr + r_stride;
                r_lane <= w_last ? '0 : r_lane + 1'b1;
            end
            if (r_state == S_WAIT) r_rdata <= w_rdata_next;
        end
    end

    // Early lanes collect in a shadow so resp_rdata only changes when a load completes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_acc
            always_ff @(posedge clk) begin
                if (rst)
                    r_acc[gi] <= '0;
                else if (r_cap_pend && (r_cap_lane == LW'(gi)))
                    r_acc[gi] <= bus.mem_rdata;
            end
            assign w_rdata_next[gi*LANE_W +: LANE_W] = r_acc[gi];
        end
    endgenerate
    assign w_rdata_next[(LANES-1)*LANE_W +: LANE_W] = bus.mem_rdata;

    assign w_en           = w_issue & ~rst;
    assign bus.req_ready  = (r_state == S_IDLE) & ~rst;
    assign bus.mem_en     = w_en;
    assign bus.mem_we     = w_en & r_write;
    assign bus.mem_addr   = w_en ? r_addr : '0;
    assign bus.mem_wdata  = (w_en & r_write) ? r_wdata[r_lane*LANE_W +: LANE_W] : '0;
    assign bus.resp_valid = (r_state == S_RESP) & ~rst;
    assign bus.resp_rdata = rst ? '0 : r_rdata;
    assign bus.busy       = (r_state != S_IDLE) & ~rst;
endmodule

// File: tb/tb_vmem_lane_sequencer.sv
// Bench for vmem_lane_sequencer: behavioural 16-word memory, table of requests,
// response scoreboard, and hand-written reset / held-valid / back-to-back sequences.
module tb_vmem_lane_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vmem_lane_sequencer_if #(.LANES(4), .LANE_W(4), .ADDR_W(4)) bus ();

    vmem_lane_sequencer #(.LANES(4), .LANE_W(4), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0]  mem [16];
    logic [15:0] sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_resp  = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  base;
        logic [3:0]  stride;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [9];

    // Memory model: one-cycle registered read, write on the strobe edge.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            n_resp++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                $display("[TB] resp %0d rdata=%h expected=%h", n_resp, bus.resp_rdata, e);
                check("resp_rdata", 32'(bus.resp_rdata), 32'(e));
            end
        end
    end

    // Starts at a negedge with the sequencer idle; returns at the negedge where it is idle again.
    task automatic do_req(input logic wr, input logic [3:0] b, input logic [3:0] s,
                          input logic [15:0] wd, input logic [15:0] exp);
        logic [3:0] ea;
        check("ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_base   = b;
        bus.req_stride = s;
        bus.req_wdata  = wd;
        sb.push_back(exp);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ea = b + 4'(k) * s;
            check("issue_en",    32'(bus.mem_en),    32'd1);
            check("issue_we",    32'(bus.mem_we),    32'(wr));
            check("issue_addr",  32'(bus.mem_addr),  32'(ea));
            check("issue_wdata", 32'(bus.mem_wdata), wr ? 32'(wd[k*4 +: 4]) : 32'd0);
            check("issue_ready", 32'(bus.req_ready), 32'd0);
            check("issue_resp",  32'(bus.resp_valid), 32'd0);
        end
        if (!wr) begin
            @(negedge clk);
            check("wait_en",   32'(bus.mem_en),     32'd0);
            check("wait_resp", 32'(bus.resp_valid), 32'd0);
            check("wait_busy", 32'(bus.busy),       32'd1);
        end
        @(negedge clk);
        check("resp_pulse", 32'(bus.resp_valid), 32'd1);
        check("resp_en",    32'(bus.mem_en),     32'd0);
        check("resp_ready", 32'(bus.req_ready),  32'd0);
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready),  32'd1);
        check("idle_busy",  32'(bus.busy),       32'd0);
        check("idle_resp",  32'(bus.resp_valid), 32'd0);
        check("idle_addr",  32'(bus.mem_addr),   32'd0);
        $display("[TB] req wr=%0d base=%h stride=%h wdata=%h", wr, b, s, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 4'd0,  4'd1,  16'h0000, 16'h3210};
        tbl[1] = '{1'b0, 4'd5,  4'd5,  16'h0000, 16'h4FA5};
        tbl[2] = '{1'b0, 4'd3,  4'd0,  16'h0000, 16'h3333};
        tbl[3] = '{1'b0, 4'd14, 4'd3,  16'h0000, 16'h741E};
        tbl[4] = '{1'b1, 4'd2,  4'd0,  16'hABCD, 16'h741E};
        tbl[5] = '{1'b0, 4'd0,  4'd1,  16'h0000, 16'h3A10};
        tbl[6] = '{1'b1, 4'd8,  4'd1,  16'h1234, 16'h3A10};
        tbl[7] = '{1'b0, 4'd8,  4'd1,  16'h0000, 16'h1234};
        tbl[8] = '{1'b0, 4'd6,  4'd15, 16'h0000, 16'h3456};

        for (int n = 0; n < 16; n++) mem[n] = 4'(n);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_base   = '0;
        bus.req_stride = '0;
        bus.req_wdata  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready),  32'd0);
        check("rst_busy",  32'(bus.busy),       32'd0);
        check("rst_en",    32'(bus.mem_en),     32'd0);
        check("rst_resp",  32'(bus.resp_valid), 32'd0);
        check("rst_rdata", 32'(bus.resp_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            do_req(tbl[i].wr, tbl[i].base, tbl[i].stride, tbl[i].wdata, tbl[i].exp);
        check("mem_after_write2", 32'(mem[2]),  32'hA);
        check("mem_after_write8", 32'(mem[11]), 32'h1);

        // req_valid held high: second accept only when idle again at T+7.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_base   = 4'd12;
        bus.req_stride = 4'd1;
        sb.push_back(16'hFEDC);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("held_ready_low", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        check("held_ready_t7", 32'(bus.req_ready), 32'd1);
        sb.push_back(16'hFEDC);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("held_second_done", 32'(bus.req_ready), 32'd1);
        check("held_sb_empty",    32'(sb.size()),     32'd0);
        $display("[TB] req held-valid read base=c stride=1 x2");

        // Reset during lane 2 of a load drops it entirely.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_base   = 4'd0;
        bus.req_stride = 4'd1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_lane2_addr", 32'(bus.mem_addr), 32'd2);
        rst = 1'b1;
        #1;
        check("rstmid_en_during",    32'(bus.mem_en),    32'd0);
        check("rstmid_ready_during", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_en",    32'(bus.mem_en),     32'd0);
        check("rstmid_busy",  32'(bus.busy),       32'd0);
        check("rstmid_ready", 32'(bus.req_ready),  32'd1);
        check("rstmid_rdata", 32'(bus.resp_rdata), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("rstmid_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        $display("[TB] req read dropped by reset");

        // Back-to-back read then write, then a read of what was written.
        do_req(1'b0, 4'd0, 4'd1, 16'h0000, 16'h3A10);
        do_req(1'b1, 4'd0, 4'd2, 16'h9876, 16'h3A10);
        do_req(1'b0, 4'd0, 4'd2, 16'h0000, 16'h9876);

        repeat (2) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("resp_count",     32'(n_resp),    32'd14);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
